// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   dmem_state_t : access FSM states
//   WS_W         : width of the wait-state counter
//   fault_t      : fault code latched with each access
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam int WS_W = 4;

   typedef logic [1:0] fault_t;
   localparam fault_t FAULT_NONE  = 2'd0;
   localparam fault_t FAULT_ALIGN = 2'd1;  // byte offset bits nonzero
   localparam fault_t FAULT_RANGE = 2'd2;  // address beyond the array

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
//   clk, reset : clock; async active-low reset (clears rdata only)
//   we         : write wdata into word idx
//   re         : register word idx into rdata
//   rdata      : holds the last read value until the next re
module dmem_array #(
   parameter int DATA_W = 30,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   // Contents are deliberately not reset.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  rdata <= '0;
      else if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: word-addressed data RAM with programmable wait
// states, stall/done handshake and fault detection.
//   clk, reset  : clock; async active-low reset
//   MemReqM     : access request (sampled only in IDLE)
//   MemWriteM   : 1 = store, 0 = load
//   AddrM       : byte address
//   WriteDataM  : store data
//   ReadDataM   : last successful load result
//   MemStallM   : access in flight, M stage must hold
//   MemDoneM    : one-cycle completion pulse
//   AddrErrM    : with MemDoneM when the access faulted
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 30,
   parameter int ADDR_W      = 30,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemReqM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] AddrM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              MemStallM,
   output logic              MemDoneM,
   output logic              AddrErrM
);

   localparam int IDX_W = $clog2(DEPTH);

   dmem_state_t       state, state_nx;
   logic [WS_W-1:0]   cnt;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   fault_t            fault_q, fault_in;
   logic              capture, commit, ok_q;

   // Range check: any address bit above the word index makes AddrM >= 4*DEPTH.
   always_comb begin
      fault_in = FAULT_NONE;
      if (AddrM[1:0] != 2'b00)               fault_in = FAULT_ALIGN;
      else if (|AddrM[ADDR_W-1:IDX_W+2])     fault_in = FAULT_RANGE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      MemStallM = 1'b0;
      MemDoneM  = 1'b0;
      AddrErrM  = 1'b0;
      capture   = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            // Gated with reset so the stall reads 0 while reset is held.
            MemStallM = MemReqM & reset;
            if (MemReqM) begin
               capture  = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            MemStallM = 1'b1;
            if (cnt == '0) begin
               commit   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            MemDoneM = 1'b1;
            AddrErrM = (fault_q != FAULT_NONE);
            state_nx = IDLE;  // MemReqM here belongs to the same access
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         fault_q <= FAULT_NONE;
      end else if (capture) begin
         cnt     <= WS_W'(WAIT_STATES);
         idx_q   <= AddrM[IDX_W+1:2];
         wdata_q <= WriteDataM;
         we_q    <= MemWriteM;
         fault_q <= fault_in;
      end else if (state == BUSY && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // The array is touched only in the commit cycle; a reset before then
   // returns the FSM to IDLE, so an aborted store never writes.
   assign ok_q = (fault_q == FAULT_NONE);

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (commit & we_q & ok_q),
      .re    (commit & ~we_q & ok_q),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ReadDataM)
   );

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined CPU's Memory stage. It receives the stage's 30-bit address and write data and returns ReadDataM.
- It models a word-addressed data RAM with a programmable wait-state count.
- It asserts MemStallM so the hazard unit can freeze F/D/E/M while an access is in flight.
- It flags misaligned or out-of-range accesses.

Parameters:
DATA_W, 30, data word width (matches datapath)
ADDR_W, 30, byte address width from ALUOutM
DEPTH, 256, number of words in the array (power of two)
WAIT_STATES, 2, extra BUSY cycles per access (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MemReqM  in  1  access request from the M stage (load or store)
MemWriteM  in  1  1 = store, 0 = load; valid with MemReqM
AddrM  in  ADDR_W  byte address (ALUOutM)
WriteDataM  in  DATA_W  store data
ReadDataM  out  DATA_W  load result; holds the last completed load
MemStallM  out  1  access in flight; the M stage must hold
MemDoneM  out  1  one-cycle pulse when an access completes
AddrErrM  out  1  one-cycle pulse with MemDoneM if the access faulted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - ReadDataM=0, MemStallM=0, MemDoneM=0, AddrErrM=0.
  - Array contents are not reset.
  - Reset mid-access aborts the access. A store not yet committed is never written.
- Word index = AddrM[log2(DEPTH)+1:2].
- Fault conditions:
  - Fault if AddrM[1:0]!=0, or AddrM >= 4*DEPTH.
  - A faulting store does not write.
  - A faulting load leaves ReadDataM unchanged.
- States:
  - IDLE:
    - MemStallM = MemReqM (combinational).
    - On MemReqM=1: latch addr, data, write-enable and fault; counter<=WAIT_STATES; go to BUSY.
  - BUSY:
    - MemStallM=1.
    - If counter!=0: counter decrements.
    - If counter==0: commit the access. A store writes the array; a load registers array data into ReadDataM. Go to DONE.
  - DONE:
    - MemStallM=0, MemDoneM=1.
    - AddrErrM = latched fault.
    - Go to IDLE unconditionally. The pipeline advances at the end of this cycle, and MemReqM in DONE is not re-captured.
- Timing:
  - Request seen in cycle 0.
  - Stall is high for cycles 0..WAIT_STATES+1.
  - Done and load data are valid in cycle WAIT_STATES+2.
  - Back-to-back requests: the next request is captured in the IDLE cycle immediately after DONE.
- MemReqM/AddrM/WriteDataM are sampled only in IDLE. Changes or deassertion during BUSY are ignored, and the latched access completes.
- ReadDataM changes only on a successful load commit or on reset.
- A store followed by a load to the same address returns the stored value. There is no read-during-write hazard, since commits are serialized.
- WAIT_STATES=0: BUSY lasts exactly one cycle (total stall 2 cycles).

Decomposition:
- Shared package dmem_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t
  - localparam WS_W=4
  - fault-code constants
- Sub-module dmem_array:
  - Single-port synchronous RAM (DATA_W x DEPTH).
  - Ports: we, word index, write data, registered read data.
  - Instantiated once; the FSM drives its enable only in the commit cycle.

Test Plan:
1. Reset, then store 30'h0ABCDEF to AddrM=30'h10 with WAIT_STATES=2 -> MemStallM high for cycles 0-3, MemDoneM=1 in cycle 4, AddrErrM=0.
2. Load from 30'h10 after test 1 -> ReadDataM=30'h0ABCDEF in cycle 4 and held afterward. Then load unwritten-then-written 30'h14=30'h5 -> ReadDataM=30'h5.
3. Load from AddrM=30'h12 (misaligned) -> AddrErrM pulses with MemDoneM; ReadDataM keeps its prior value. Store to 30'h400 (DEPTH=256) -> AddrErrM pulses; a later load of 30'h0 is unchanged.
4. Back-to-back requests held asserted: store 30'h7 to 30'h20, then load 30'h20 -> second capture in the cycle after DONE; load returns 30'h7; total 10 cycles.
5. Assert reset low in cycle 2 of a store of 30'h3 to 30'h24 -> outputs go to 0 immediately, state=IDLE; a subsequent load of 30'h24 returns its pre-store value (no write).
6. WAIT_STATES=0 build: load -> MemStallM high exactly 2 cycles, MemDoneM in cycle 2. Dropping MemReqM during BUSY still yields MemDoneM.
